// File: rtl/extmem_port_if.sv
// extmem_port_if: controller strobe side and off-chip memory request/return side of extmem_port
interface extmem_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16,
    parameter int FIFO_D = 8
);
    logic                      we_i, re_i, clr_err_i, mem_gnt_i, mem_rvalid_i;
    logic [ADDR_W-1:0]         wr_addr_i, rd_addr_i, mem_addr_o;
    logic [DATA_W-1:0]         wr_data_i, mem_rdata_i, rd_data_o, mem_wdata_o;
    logic                      rd_valid_o, busy_o, err_overflow_o, err_spurious_o, mem_req_o, mem_we_o;
    logic [$clog2(FIFO_D):0]   cmd_space_o;

    modport slave (
        input  we_i, wr_addr_i, wr_data_i, re_i, rd_addr_i, clr_err_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output rd_data_o, rd_valid_o, busy_o, cmd_space_o, err_overflow_o, err_spurious_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output we_i, wr_addr_i, wr_data_i, re_i, rd_addr_i, clr_err_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  rd_data_o, rd_valid_o, busy_o, cmd_space_o, err_overflow_o, err_spurious_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/extmem_port.sv
// extmem_port: queues one-cycle controller memory strobes and replays them in order over a
// req/gnt + rvalid memory handshake, bounding reads in flight and returning read data in order.
module extmem_port #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 16,
    parameter int FIFO_D  = 8,
    parameter int MAX_OUT = 4
) (
    input logic clk,
    input logic rst_n,
    extmem_port_if.slave bus
);
    localparam int AW = $clog2(FIFO_D);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RD_STALL} state_t;

    state_t            state_q, state_d;
    cmd_t              fifo_q [FIFO_D];
    cmd_t              sel;
    logic [AW-1:0]     wp_q, rp_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW:0]       free;
    logic [OW-1:0]     out_q, out_d;
    logic              pop, rd_gnt, rv_ok, spur, w_ok, r_ok, ovf, avail, go, load, req_d;
    logic              rd_valid_q, busy_q, err_ovf_q, err_spur_q, mem_req_q, mem_we_q;
    logic [DATA_W-1:0] rd_data_q, mem_wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;

    // A pop this cycle frees its slot before the strobes are admitted.
    assign pop    = state_q == ISSUE && bus.mem_gnt_i;
    assign free   = {1'b0, CW'(FIFO_D) - cnt_q} + (CW+1)'(pop);
    assign w_ok   = bus.we_i && free != '0;
    assign r_ok   = bus.re_i && free > (w_ok ? (CW+1)'(1) : (CW+1)'(0));
    assign ovf    = (bus.we_i && !w_ok) || (bus.re_i && !r_ok);
    assign cnt_d  = cnt_q + CW'(w_ok) + CW'(r_ok) - CW'(pop);
    assign rd_gnt = pop && !mem_we_q;
    assign rv_ok  = bus.mem_rvalid_i && out_q != '0;
    assign spur   = bus.mem_rvalid_i && out_q == '0;
    assign out_d  = out_q + OW'(rd_gnt) - OW'(rv_ok);

    // While issuing, the candidate is the entry behind the one being granted.
    assign sel   = fifo_q[state_q == ISSUE ? rp_q + 1'b1 : rp_q];
    assign avail = state_q == ISSUE ? cnt_q > CW'(1) : cnt_q != '0;
    assign go    = sel.we || out_d < OW'(MAX_OUT);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    always_comb begin
        state_d = state_q == RD_STALL       ? (go ? ISSUE : RD_STALL) :
                  (state_q == ISSUE && !pop) ? ISSUE :
                  !avail                     ? IDLE :
                  go                         ? ISSUE : RD_STALL;
    end

    always_comb begin
        req_d = state_d == ISSUE;
        load  = req_d && (state_q != ISSUE || pop);
    end

    always_ff @(posedge clk) begin
        if (w_ok) fifo_q[wp_q] <= {1'b1, bus.wr_addr_i, bus.wr_data_i};
        if (r_ok) fifo_q[w_ok ? wp_q + 1'b1 : wp_q] <= {1'b0, bus.rd_addr_i, {DATA_W{1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            busy_q      <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_spur_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            wp_q       <= wp_q + AW'(w_ok) + AW'(r_ok);
            rp_q       <= rp_q + AW'(pop);
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            rd_valid_q <= rv_ok;
            if (rv_ok) rd_data_q <= bus.mem_rdata_i;
            busy_q     <= cnt_d != '0 || out_d != '0 || req_d;
            err_ovf_q  <= ovf || (err_ovf_q && !bus.clr_err_i);
            err_spur_q <= spur || (err_spur_q && !bus.clr_err_i);
            mem_req_q  <= req_d;
            if (load) {mem_we_q, mem_addr_q, mem_wdata_q} <= sel;
        end
    end

    assign bus.rd_valid_o     = rd_valid_q;
    assign bus.rd_data_o      = rd_data_q;
    assign bus.busy_o         = busy_q;
    assign bus.cmd_space_o    = CW'(FIFO_D) - cnt_q;
    assign bus.err_overflow_o = err_ovf_q;
    assign bus.err_spurious_o = err_spur_q;
    assign bus.mem_req_o      = mem_req_q;
    assign bus.mem_we_o       = mem_we_q;
    assign bus.mem_addr_o     = mem_addr_q;
    assign bus.mem_wdata_o    = mem_wdata_q;
endmodule

// File: tb/tb_extmem_port.sv
// tb_extmem_port: directed vectors plus hand sequences against a small memory model with
// programmable grant, delayed in-order read return and injected stray returns.
module tb_extmem_port;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    extmem_port_if b ();
    extmem_port dut (.clk(clk), .rst_n(rst_n), .bus(b.slave));

    typedef struct {
        int          due;
        logic [15:0] d;
    } rq_t;

    typedef struct {
        logic        we, re, clr, gnt;
        logic [31:0] addr;
        logic [3:0]  space;
        logic        ovf, req;
        logic [31:0] maddr;
    } vec_t;

    int          n_chk = 0, n_fail = 0, cyc = 0, nrv = 0, base = 0;
    bit          auto_gnt = 1'b0, auto_rv = 1'b0, inject = 1'b0;
    logic [15:0] got [$];
    logic [32:0] log_q [$];
    logic [15:0] mm [logic [31:0]];
    rq_t         rq [$];
    vec_t        tv [15];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: acts 2 time units after each falling edge, after the stimulus has settled.
    initial begin : model
        rq_t t;
        b.mem_gnt_i = 1'b0;
        b.mem_rvalid_i = 1'b0;
        b.mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) rq.delete();
            b.mem_gnt_i = auto_gnt && b.mem_req_o && rst_n;
            if (b.mem_gnt_i) begin
                log_q.push_back({b.mem_we_o, b.mem_addr_o});
                if (b.mem_we_o) mm[b.mem_addr_o] = b.mem_wdata_o;
                else begin
                    t.due = cyc + 3;
                    t.d = mm.exists(b.mem_addr_o) ? mm[b.mem_addr_o] : (b.mem_addr_o[15:0] ^ 16'hA5A5);
                    rq.push_back(t);
                end
            end
            b.mem_rvalid_i = 1'b0;
            b.mem_rdata_i = '0;
            if (inject) begin
                b.mem_rvalid_i = 1'b1;
                b.mem_rdata_i = 16'h5A5A;
            end else if (auto_rv && rq.size() > 0 && rq[0].due <= cyc) begin
                t = rq.pop_front();
                b.mem_rvalid_i = 1'b1;
                b.mem_rdata_i = t.d;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (b.rd_valid_o) begin
            nrv++;
            got.push_back(b.rd_data_o);
        end
    endtask

    task automatic idle_inputs();
        b.we_i = 1'b0;
        b.re_i = 1'b0;
        b.clr_err_i = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        for (int k = 0; k < bound && b.busy_o; k++) tick();
        chk(name, b.busy_o, 0);
    endtask

    task automatic push_reads(input logic [31:0] a0, input int n);
        for (int i = 0; i < n; i++) begin
            b.re_i = 1'b1;
            b.rd_addr_i = a0 + 32'(i);
            tick();
        end
        idle_inputs();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int j;
        logic [15:0] e;
        idle_inputs();
        b.wr_addr_i = '0;
        b.wr_data_i = '0;
        b.rd_addr_i = '0;

        tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 4'd7, 1'b0, 1'b0, 32'h0};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h11, 4'd6, 1'b0, 1'b1, 32'h10};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h12, 4'd5, 1'b0, 1'b1, 32'h10};
        tv[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 4'd4, 1'b0, 1'b1, 32'h10};
        tv[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h14, 4'd3, 1'b0, 1'b1, 32'h10};
        tv[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h15, 4'd2, 1'b0, 1'b1, 32'h10};
        tv[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h16, 4'd1, 1'b0, 1'b1, 32'h10};
        tv[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h17, 4'd0, 1'b0, 1'b1, 32'h10};
        tv[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h18, 4'd0, 1'b1, 1'b1, 32'h10};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  4'd0, 1'b0, 1'b1, 32'h10};
        tv[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h19, 4'd0, 1'b1, 1'b1, 32'h10};
        tv[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  4'd0, 1'b0, 1'b1, 32'h10};
        tv[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  4'd1, 1'b0, 1'b1, 32'h11};
        tv[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h30, 4'd0, 1'b1, 1'b1, 32'h11};
        tv[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h32, 4'd0, 1'b0, 1'b1, 32'h12};

        repeat (3) @(negedge clk);
        chk("rst_req", b.mem_req_o, 0);
        chk("rst_we", b.mem_we_o, 0);
        chk("rst_addr", b.mem_addr_o, 0);
        chk("rst_wdata", b.mem_wdata_o, 0);
        chk("rst_rd_valid", b.rd_valid_o, 0);
        chk("rst_rd_data", b.rd_data_o, 0);
        chk("rst_busy", b.busy_o, 0);
        chk("rst_space", b.cmd_space_o, 8);
        chk("rst_ovf", b.err_overflow_o, 0);
        chk("rst_spur", b.err_spurious_o, 0);
        rst_n = 1'b1;
        tick();
        tick();

        // Fill, overflow, error clear priority, pop-before-push on a full FIFO.
        for (int i = 0; i < 15; i++) begin
            b.we_i = tv[i].we;
            b.re_i = tv[i].re;
            b.clr_err_i = tv[i].clr;
            b.wr_addr_i = tv[i].addr;
            b.wr_data_i = tv[i].addr[15:0] ^ 16'h1111;
            b.rd_addr_i = tv[i].addr + 32'd1;
            auto_gnt = tv[i].gnt;
            tick();
            chk($sformatf("v%0d_space", i), b.cmd_space_o, tv[i].space);
            chk($sformatf("v%0d_ovf", i), b.err_overflow_o, tv[i].ovf);
            chk($sformatf("v%0d_req", i), b.mem_req_o, tv[i].req);
            chk($sformatf("v%0d_maddr", i), b.mem_addr_o, tv[i].maddr);
        end
        idle_inputs();
        auto_gnt = 1'b1;
        tick();
        drain("drain_fill", 100);
        chk("drain_space", b.cmd_space_o, 8);

        // Four reads, immediate grant, 3-cycle return.
        auto_rv = 1'b1;
        nrv = 0;
        got.delete();
        base = log_q.size();
        push_reads(32'h100, 4);
        drain("t1_busy", 80);
        chk("t1_count", nrv, 4);
        for (int i = 0; i < got.size() && i < 4; i++) begin
            e = 16'(32'h100 + 32'(i)) ^ 16'hA5A5;
            chk($sformatf("t1_data%0d", i), got[i], e);
        end
        j = 0;
        for (int i = base; i < log_q.size(); i++)
            if (!log_q[i][32]) begin
                chk($sformatf("t1_addr%0d", j), log_q[i][31:0], 32'h100 + 32'(j));
                j++;
            end
        chk("t1_issued", j, 4);

        // Outstanding-read limit and stall release.
        auto_rv = 1'b0;
        nrv = 0;
        got.delete();
        base = log_q.size();
        push_reads(32'h200, 6);
        repeat (20) tick();
        chk("t3_grants4", log_q.size() - base, 4);
        chk("t3_stall_req", b.mem_req_o, 0);
        chk("t3_busy", b.busy_o, 1);
        auto_rv = 1'b1;
        tick();
        auto_rv = 1'b0;
        repeat (10) tick();
        chk("t3_grants5", log_q.size() - base, 5);
        chk("t3_stall_req2", b.mem_req_o, 0);
        chk("t3_ret1", nrv, 1);
        auto_rv = 1'b1;
        drain("t3_busy_end", 100);
        chk("t3_count", nrv, 6);
        for (int i = 0; i < got.size() && i < 6; i++) begin
            e = 16'(32'h200 + 32'(i)) ^ 16'hA5A5;
            chk($sformatf("t3_data%0d", i), got[i], e);
        end

        // Same-cycle write and read to one address.
        nrv = 0;
        got.delete();
        base = log_q.size();
        b.we_i = 1'b1;
        b.wr_addr_i = 32'h20;
        b.wr_data_i = 16'hBEEF;
        b.re_i = 1'b1;
        b.rd_addr_i = 32'h20;
        tick();
        idle_inputs();
        drain("t4_busy", 80);
        chk("t4_first", log_q.size() > base ? log_q[base] : 33'h0, {1'b1, 32'h20});
        chk("t4_second", log_q.size() > base + 1 ? log_q[base + 1] : 33'h0, {1'b0, 32'h20});
        chk("t4_count", nrv, 1);
        chk("t4_data", got.size() > 0 ? got[0] : 16'h0, 16'hBEEF);

        // Asynchronous reset with three reads in flight.
        auto_rv = 1'b0;
        base = log_q.size();
        push_reads(32'h300, 3);
        repeat (10) tick();
        chk("t6_grants", log_q.size() - base, 3);
        chk("t6_busy_pre", b.busy_o, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_req", b.mem_req_o, 0);
        chk("t6_addr", b.mem_addr_o, 0);
        chk("t6_busy", b.busy_o, 0);
        chk("t6_space", b.cmd_space_o, 8);
        chk("t6_rd_valid", b.rd_valid_o, 0);
        chk("t6_spur", b.err_spurious_o, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Stray return with nothing outstanding.
        nrv = 0;
        inject = 1'b1;
        tick();
        inject = 1'b0;
        chk("t5_spur", b.err_spurious_o, 1);
        chk("t5_rd_valid", b.rd_valid_o, 0);
        tick();
        tick();
        chk("t5_no_ret", nrv, 0);
        b.clr_err_i = 1'b1;
        tick();
        b.clr_err_i = 1'b0;
        chk("t5_clr", b.err_spurious_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
